// File: rtl/timer_capture.sv
// timer_capture
//   Event timestamp capture stage. EVENT_IN is synchronised into the CLOCK
//   domain and edge-detected. Each qualifying edge writes {edge type, COUNT_IN}
//   into a small show-ahead FIFO. The controller drains it with RD_EN while
//   Q_VALID is high. A sticky OVERFLOW bit records any edge lost to a full FIFO.
//
// Parameters
//   DATA_WIDTH   width of COUNT_IN / Q_DATA
//   FIFO_DEPTH   capture FIFO entries (power of two, >= 2)
//   SYNC_STAGES  synchroniser flops on EVENT_IN (>= 2)
//
// Ports
//   CLOCK     in   clock, same domain as the timer counter
//   RESET     in   asynchronous, active-high reset
//   COUNT_IN  in   current timer counter value
//   EVENT_IN  in   asynchronous event line
//   ARM       in   edges are captured only while high
//   CLEAR     in   single-cycle flush of FIFO and OVERFLOW
//   RD_EN     in   pop request, honoured only while Q_VALID is high
//   Q_DATA    out  timestamp at the FIFO head (held when empty)
//   Q_EDGE    out  edge type at the FIFO head, 1 = rising, 0 = falling
//   Q_VALID   out  FIFO not empty
//   FULL      out  FIFO holds FIFO_DEPTH entries
//   OVERFLOW  out  sticky: at least one event was dropped
//   LEVEL     out  current entry count
//
// Build option
//   TIMER_CAPTURE_BOTH_EDGES_EN  when defined, falling edges are captured too
//                                (Q_EDGE = 0); otherwise only rising edges.

module timer_capture #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic [DATA_WIDTH-1:0]         COUNT_IN,
  input  logic                          EVENT_IN,
  input  logic                          ARM,
  input  logic                          CLEAR,
  input  logic                          RD_EN,
  output logic [DATA_WIDTH-1:0]         Q_DATA,
  output logic                          Q_EDGE,
  output logic                          Q_VALID,
  output logic                          FULL,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 1;

  // synchroniser and edge detector
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               valid_q, valid_d;
  logic               full_q, full_d;
  logic               ovf_q, ovf_d;
  logic [ENTRY_W-1:0] q_word_q, q_word_d;

  logic               sync_level;
  logic               edge_det;
  logic               edge_type;
  logic               capture;
  logic               do_pop;
  logic               do_wr;
  logic [ENTRY_W-1:0] wr_word;

  assign sync_level = sync_q[SYNC_STAGES-1];

`ifdef TIMER_CAPTURE_BOTH_EDGES_EN
  assign edge_det  = sync_level ^ prev_q;
  assign edge_type = sync_level;
`else
  assign edge_det  = sync_level & ~prev_q;
  assign edge_type = 1'b1;
`endif

  // The edge detector always runs; ARM only gates the write, so raising ARM
  // while EVENT_IN is already high cannot look like a fresh edge.
  assign capture = edge_det & ARM;
  assign do_pop  = RD_EN & valid_q;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign do_wr   = capture & (~full_q | do_pop);
  assign wr_word = {edge_type, COUNT_IN};

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], EVENT_IN};
    prev_d   = sync_level;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    q_word_d = q_word_q;

    if (CLEAR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      full_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_word;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_wr, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (capture && !do_wr) begin
        ovf_d = 1'b1;
      end
      valid_d = (level_d != '0);
      full_d  = (level_d == LVL_W'(FIFO_DEPTH));
      // Registered head: when the incoming word is the only entry left it is
      // not in mem_q yet, so bypass it; otherwise the head is already stored.
      // With nothing left the head register simply holds its last value.
      if (do_wr && level_d == LVL_W'(1)) begin
        q_word_d = wr_word;
      end else if (level_d != '0) begin
        q_word_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      q_word_q <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      q_word_q <= q_word_d;
    end
  end

  assign Q_DATA   = q_word_q[DATA_WIDTH-1:0];
  assign Q_EDGE   = q_word_q[DATA_WIDTH];
  assign Q_VALID  = valid_q;
  assign FULL     = full_q;
  assign OVERFLOW = ovf_q;
  assign LEVEL    = level_q;

endmodule

// File: tb/tb_timer_capture.sv
// tb_timer_capture
//   Self-checking bench for timer_capture (default parameters). Inputs change
//   on the falling clock edge; outputs are sampled there too. COUNT_IN steps
//   by one every cycle, so a capture driven at a falling edge stores
//   count_in + SYNC_STAGES. Expected entries are queued when an edge is driven
//   and compared when the entry reaches the FIFO head and is popped.
//   Falling-edge entries are expected only when TIMER_CAPTURE_BOTH_EDGES_EN
//   is defined.

module tb_timer_capture;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] count_in;
  logic          event_in;
  logic          arm;
  logic          clear;
  logic          rd_en;
  logic [DW-1:0] q_data;
  logic          q_edge;
  logic          q_valid;
  logic          full;
  logic          overflow;
  logic [$clog2(DEPTH):0] level;

  timer_capture #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLOCK   (clk),
    .RESET   (rst),
    .COUNT_IN(count_in),
    .EVENT_IN(event_in),
    .ARM     (arm),
    .CLEAR   (clear),
    .RD_EN   (rd_en),
    .Q_DATA  (q_data),
    .Q_EDGE  (q_edge),
    .Q_VALID (q_valid),
    .FULL    (full),
    .OVERFLOW(overflow),
    .LEVEL   (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic arm;
    logic ev;
    logic rd;
    logic clr;
    int   hold;
    logic push;   // this record's rising edge is expected to be stored
    logic pop;    // this record's RD_EN is expected to remove the head
    int   lvl;
    logic ovf;
    logic valid;
    logic full;
  } vec_t;

  vec_t        vq[$];
  logic [DW:0] sb[$];
  logic [DW:0] last_pop;
  int          checks;
  int          failures;

  task automatic tick();
    @(negedge clk);
    count_in = count_in + 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic expect_capture(input logic edge_type);
    sb.push_back({edge_type, count_in + DW'(SYNC)});
  endtask

  task automatic check_head(input string nm);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard has no expected entry", nm);
    end else begin
      chk({nm, "_valid"}, 32'(q_valid), 32'd1);
      chk({nm, "_data"}, 32'(q_data), 32'(sb[0][DW-1:0]));
      chk({nm, "_edge"}, 32'(q_edge), 32'(sb[0][DW]));
    end
  endtask

  task automatic pop_one(input string nm);
    check_head(nm);
    if (sb.size() != 0) last_pop = sb.pop_front();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic add(input logic a, input logic e, input logic r, input logic c, input int h,
                     input logic pu, input logic po, input int l, input logic o,
                     input logic v, input logic f);
    vec_t x;
    x = '{arm: a, ev: e, rd: r, clr: c, hold: h, push: pu, pop: po,
          lvl: l, ovf: o, valid: v, full: f};
    vq.push_back(x);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      vec_t v;
      v = vq[i];
      if (v.pop) begin
        check_head($sformatf("vec%0d_head", i));
        if (sb.size() != 0) last_pop = sb.pop_front();
      end
      arm      = v.arm;
      event_in = v.ev;
      rd_en    = v.rd;
      clear    = v.clr;
      if (v.push) expect_capture(1'b1);
      if (v.clr) sb.delete();
      repeat (v.hold) begin
        tick();
        rd_en = 1'b0;
        clear = 1'b0;
      end
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(v.lvl));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(v.ovf));
      chk($sformatf("vec%0d_valid", i), 32'(q_valid), 32'(v.valid));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(v.full));
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_qdata"}, 32'(q_data), 32'd0);
    chk({nm, "_qedge"}, 32'(q_edge), 32'd0);
    chk({nm, "_qvalid"}, 32'(q_valid), 32'd0);
    chk({nm, "_full"}, 32'(full), 32'd0);
    chk({nm, "_overflow"}, 32'(overflow), 32'd0);
    chk({nm, "_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    count_in = '0;
    event_in = 1'b0;
    arm      = 1'b0;
    clear    = 1'b0;
    rd_en    = 1'b0;

    // Falling edges are always driven together with ARM low so they are
    // discarded in either build; only the dedicated both-edges test differs.
    // ARM gating and overflow (0..16)
    add(0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0);  // rise while disarmed
    add(1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0);  // ARM rises with event already high
    add(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 3, 1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 3, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 3, 1, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 3, 0, 0, 2, 0, 1, 0);
    add(1, 1, 0, 0, 3, 1, 0, 3, 0, 1, 0);
    add(0, 0, 0, 0, 3, 0, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0, 3, 1, 0, 4, 0, 1, 1);
    add(0, 0, 0, 0, 3, 0, 0, 4, 0, 1, 1);
    add(0, 1, 0, 0, 3, 0, 0, 4, 0, 1, 1);  // disarmed edge while full: no flag
    add(0, 0, 0, 0, 3, 0, 0, 4, 0, 1, 1);
    add(1, 1, 0, 0, 3, 0, 0, 4, 1, 1, 1);  // fifth armed edge dropped
    add(0, 0, 0, 0, 3, 0, 0, 4, 1, 1, 1);
    add(0, 0, 1, 0, 1, 0, 1, 3, 1, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 2, 1, 1, 0);
    // read while empty, then refill (17..25)
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 3, 1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 3, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 3, 1, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 3, 0, 0, 2, 0, 1, 0);
    add(1, 1, 0, 0, 3, 1, 0, 3, 0, 1, 0);
    add(0, 0, 0, 0, 3, 0, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0, 3, 1, 0, 4, 0, 1, 1);
    add(0, 0, 0, 0, 3, 0, 0, 4, 0, 1, 1);
    // drain after simultaneous push/pop (26..29)
    add(0, 0, 1, 0, 1, 0, 1, 3, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 2, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);

    // reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // basic capture with latency checks
    arm = 1'b1;
    repeat (2) tick();
    event_in = 1'b1;
    expect_capture(1'b1);
    tick();
    chk("lat_edge_k_valid", 32'(q_valid), 32'd0);
    tick();
    chk("lat_edge_k1_valid", 32'(q_valid), 32'd0);
    tick();
    chk("lat_edge_k2_level", 32'(level), 32'd1);
    pop_one("basic");
    chk("basic_pop_valid", 32'(q_valid), 32'd0);
    chk("basic_pop_level", 32'(level), 32'd0);
    chk("basic_hold_data", 32'(q_data), 32'(last_pop[DW-1:0]));
    arm      = 1'b0;
    event_in = 1'b0;
    repeat (3) tick();

    run_vecs(0, 16);

    // CLEAR beats a coincident edge and RD_EN with LEVEL = 2, OVERFLOW = 1
    arm      = 1'b1;
    event_in = 1'b1;
    repeat (2) tick();
    clear = 1'b1;
    rd_en = 1'b1;
    tick();
    clear = 1'b0;
    rd_en = 1'b0;
    sb.delete();
    chk("clear_level", 32'(level), 32'd0);
    chk("clear_overflow", 32'(overflow), 32'd0);
    chk("clear_valid", 32'(q_valid), 32'd0);
    arm      = 1'b0;
    event_in = 1'b0;
    repeat (3) tick();
    chk("clear_edge_dropped", 32'(level), 32'd0);

    run_vecs(17, 25);

    // full FIFO: edge lands in the same cycle as a pop
    arm      = 1'b1;
    event_in = 1'b1;
    expect_capture(1'b1);
    repeat (2) tick();
    pop_one("fullpp");
    chk("fullpp_level", 32'(level), 32'd4);
    chk("fullpp_overflow", 32'(overflow), 32'd0);
    chk("fullpp_full", 32'(full), 32'd1);
    arm      = 1'b0;
    event_in = 1'b0;
    repeat (3) tick();

    run_vecs(26, 29);

    // 5-cycle high pulse: falling entry only with the both-edges build
    arm      = 1'b1;
    event_in = 1'b1;
    expect_capture(1'b1);
    repeat (5) tick();
    event_in = 1'b0;
`ifdef TIMER_CAPTURE_BOTH_EDGES_EN
    expect_capture(1'b0);
`endif
    repeat (3) tick();
    arm = 1'b0;
    tick();
    chk("pulse_level", 32'(level), 32'(sb.size()));
    n = sb.size();
    for (int i = 0; i < n; i++) pop_one($sformatf("pulse%0d", i));
    chk("pulse_drained", 32'(q_valid), 32'd0);

    // reset released with EVENT_IN already high
    rst      = 1'b1;
    event_in = 1'b1;
    arm      = 1'b1;
    repeat (2) tick();
    check_all_zero("rst_hold");
    rst = 1'b0;
    expect_capture(1'b1);
    repeat (5) tick();
    chk("rst_rel_level", 32'(level), 32'd1);
    check_head("rst_rel");

    // asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    sb.delete();
    arm      = 1'b0;
    event_in = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
